// File: rtl/multicast_scheduler.sv
// Multicast bus scheduler: streams PE IDs into the MCCs, then issues
// tagged FIFO items all-or-nothing to every PE whose ID matches the tag.
module multicast_scheduler #(
    parameter int numPE = 12,
    parameter int idBits = 8,
    parameter int dataSize = 8,
    parameter int fifoDepth = 4,
    parameter logic [idBits-1:0] idleTag = '1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_start_i,
    input  logic                cfg_valid_i,
    input  logic [idBits-1:0]   cfg_id_i,
    output logic                cfg_ready_o,
    output logic                cfg_done_o,
    output logic                cfg_err_o,
    output logic [numPE-1:0]    id_write_o,
    output logic [idBits-1:0]   id_wr_data_o,
    input  logic                cast_start_i,
    input  logic                cast_stop_i,
    input  logic                in_valid_i,
    input  logic [idBits-1:0]   in_tag_i,
    input  logic [dataSize-1:0] in_data_i,
    output logic                in_ready_o,
    input  logic [numPE-1:0]    pe_ready_i,
    output logic                mcc_enable_o,
    output logic                cast_valid_o,
    output logic [idBits-1:0]   cast_tag_o,
    output logic [dataSize-1:0] cast_data_o,
    output logic [15:0]         issued_cnt_o,
    output logic [15:0]         dropped_cnt_o
);
    localparam int IW = (numPE > 1) ? $clog2(numPE) : 1;
    localparam int PW = $clog2(fifoDepth);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONFIG = 2'd1,
        CAST   = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic [IW-1:0]       idx_q;
    logic [idBits-1:0]   shadow_q [numPE];
    logic [numPE-1:0]    id_write_q;
    logic [idBits-1:0]   id_data_q;
    logic                done_q, err_q, stop_q;
    logic [idBits-1:0]   ftag_q [fifoDepth];
    logic [dataSize-1:0] fdata_q [fifoDepth];
    logic [PW:0]         wp_q, rp_q;
    logic                cv_q;
    logic [idBits-1:0]   ctag_q;
    logic [dataSize-1:0] cdata_q;
    logic [15:0]         iss_q, drp_q;

    logic                full, empty;
    logic                cfg_hs, cfg_last, push, pop, issue, drop;
    logic [numPE-1:0]    mask;
    logic [idBits-1:0]   head_tag;
    logic [dataSize-1:0] head_data;

    assign empty     = wp_q == rp_q;
    assign full      = (wp_q[PW] != rp_q[PW]) && (wp_q[PW-1:0] == rp_q[PW-1:0]);
    assign head_tag  = ftag_q[rp_q[PW-1:0]];
    assign head_data = fdata_q[rp_q[PW-1:0]];

    assign cfg_ready_o = state_q == CONFIG;
    assign in_ready_o  = !full && (state_q != CONFIG);
    assign cfg_hs      = cfg_valid_i && cfg_ready_o;
    assign cfg_last    = idx_q == IW'(numPE - 1);
    assign push        = in_valid_i && in_ready_o;

    // Idle-tag shadow entries are unconfigured PEs and must never match.
    always_comb begin
        mask = '0;
        for (int i = 0; i < numPE; i++) begin
            mask[i] = (shadow_q[i] == head_tag) && (shadow_q[i] != idleTag);
        end
    end

    assign issue = (state_q == CAST) && !empty && (mask != '0)
                 && ((mask & ~pe_ready_i) == '0);
    assign drop  = (state_q == CAST) && !empty && (mask == '0);
    assign pop   = issue || drop;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (cfg_start_i) state_d = CONFIG;
                else if (cast_start_i) state_d = CAST;
            end
            CONFIG: if (cfg_hs && cfg_last) state_d = IDLE;
            CAST:   if (stop_q && empty) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            id_write_q <= '0;
            id_data_q  <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            stop_q     <= 1'b0;
            wp_q       <= '0;
            rp_q       <= '0;
            cv_q       <= 1'b0;
            ctag_q     <= idleTag;
            cdata_q    <= '0;
            iss_q      <= '0;
            drp_q      <= '0;
            for (int i = 0; i < numPE; i++) shadow_q[i] <= idleTag;
        end else begin
            state_q    <= state_d;
            id_write_q <= cfg_hs ? (numPE'(1) << idx_q) : '0;
            id_data_q  <= cfg_hs ? cfg_id_i : '0;
            done_q     <= id_write_q[numPE-1];
            if (cfg_hs) begin
                shadow_q[idx_q] <= cfg_id_i;
                idx_q <= cfg_last ? '0 : idx_q + IW'(1);
                if (cfg_id_i == idleTag) err_q <= 1'b1;
            end
            stop_q <= (state_q == CAST && state_d == CAST) ? (stop_q | cast_stop_i) : 1'b0;
            if (push) wp_q <= wp_q + 1'b1;
            if (pop) rp_q <= rp_q + 1'b1;
            cv_q    <= issue;
            ctag_q  <= issue ? head_tag : idleTag;
            cdata_q <= issue ? head_data : '0;
            if (issue && iss_q != 16'hFFFF) iss_q <= iss_q + 16'd1;
            if (drop && drp_q != 16'hFFFF) drp_q <= drp_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ftag_q[wp_q[PW-1:0]]  <= in_tag_i;
            fdata_q[wp_q[PW-1:0]] <= in_data_i;
        end
    end

    assign cfg_done_o    = done_q;
    assign cfg_err_o     = err_q;
    assign id_write_o    = id_write_q;
    assign id_wr_data_o  = id_data_q;
    assign mcc_enable_o  = state_q == CAST;
    assign cast_valid_o  = cv_q;
    assign cast_tag_o    = ctag_q;
    assign cast_data_o   = cdata_q;
    assign issued_cnt_o  = iss_q;
    assign dropped_cnt_o = drp_q;
endmodule
